add_pipe: RTL and testbench

ADD_PIPE -- requirements
Module: add_pipe

---
 rtl/add_pipe_pkg.sv | 26 ++
 rtl/add_pipe_stage.sv | 39 +++
 rtl/add_pipe.sv | 130 +++++++++++++
 tb/tb_add_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// ============================================================================
// Module      : add_pipe_pkg
// Description : Shared mode encoding and helpers for the add_pipe block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_pipe_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_ACC = 2'd2,
        MODE_CLR = 2'd3
    } mode_e;

    // Modes whose accepted transfer rewrites the running accumulator.
    function automatic logic touches_acc(input mode_e m);
        return (m == MODE_ACC) || (m == MODE_CLR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_pipe_stage.sv
// ============================================================================
// Module      : add_pipe_stage
// Description : One pipeline slot: valid flag plus payload, loaded on enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_pipe_stage #(
    parameter int PW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    output logic [PW-1:0] out_data
);

    logic          r_valid;
    logic [PW-1:0] r_data;

    // Bubbles are loaded like real entries so the slot order is preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (en) begin
            r_valid <= in_valid;
            r_data  <= in_data;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/add_pipe.sv
// ============================================================================
// Module      : add_pipe
// Description : Pipelined add/sub/accumulate unit with valid/ready handshake.
//               Optional macro ADD_PIPE_SAT_EN selects unsigned saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [MODE_W-1:0] mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  c,
    output logic              cout,
    output logic              ovf
);

    localparam int PW = WIDTH + 2;

    mode_e            w_mode;
    logic             w_advance;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_accsum;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] r_acc;

    logic             w_vld [LAT+1];
    logic [PW-1:0]    w_dat [LAT+1];

    assign w_mode    = mode_e'(mode);
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_accept  = in_valid && w_advance;

    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_diff   = {1'b0, a} - {1'b0, b};
    assign w_accsum = {1'b0, r_acc} + {1'b0, a};

    // SUB reports "no borrow" on cout, so the borrow bit is inverted.
    always_comb begin
        w_raw  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (w_mode)
            MODE_ADD: begin
                w_raw  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            MODE_SUB: begin
                w_raw  = w_diff[WIDTH-1:0];
                w_cout = !w_diff[WIDTH];
                w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            MODE_ACC: begin
                w_raw  = w_accsum[WIDTH-1:0];
                w_cout = w_accsum[WIDTH];
                w_ovf  = (r_acc[WIDTH-1] == a[WIDTH-1]) && (w_accsum[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                w_raw  = '0;
                w_cout = 1'b0;
                w_ovf  = 1'b0;
            end
        endcase
    end

`ifdef ADD_PIPE_SAT_EN
    always_comb begin
        w_res = w_raw;
        if (((w_mode == MODE_ADD) || (w_mode == MODE_ACC)) && w_cout) begin
            w_res = '1;
        end else if ((w_mode == MODE_SUB) && !w_cout) begin
            w_res = '0;
        end
    end
`else
    assign w_res = w_raw;
`endif

    // CLR produces a zero result, so storing w_res covers both ACC and CLR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept && touches_acc(w_mode)) begin
            r_acc <= w_res;
        end
    end

    assign w_vld[0] = in_valid;
    assign w_dat[0] = {w_res, w_cout, w_ovf};

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            add_pipe_stage #(
                .PW (PW)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (w_advance),
                .in_valid  (w_vld[gi]),
                .in_data   (w_dat[gi]),
                .out_valid (w_vld[gi+1]),
                .out_data  (w_dat[gi+1])
            );
        end
    endgenerate

    assign out_valid        = w_vld[LAT];
    assign {c, cout, ovf}   = w_dat[LAT];

endmodule

`default_nettype wire

// File: tb/tb_add_pipe.sv
// ============================================================================
// Module      : tb_add_pipe
// Description : Directed self-checking bench for add_pipe (WIDTH=16, LAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_pipe;
    import add_pipe_pkg::*;

    localparam int WIDTH = 16;
    localparam int LAT   = 2;

`ifdef ADD_PIPE_SAT_EN
    localparam logic [15:0] E_FFFF_P2  = 16'hFFFF;
    localparam logic [15:0] E_3_M_5    = 16'h0000;
    localparam logic [15:0] E_8000_P2X = 16'hFFFF;
`else
    localparam logic [15:0] E_FFFF_P2  = 16'h0001;
    localparam logic [15:0] E_3_M_5    = 16'hFFFE;
    localparam logic [15:0] E_8000_P2X = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [MODE_W-1:0] mode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  c;
    logic              cout;
    logic              ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  tv_mode [8];
    logic [15:0] tv_a    [8];
    logic [15:0] tv_b    [8];
    logic [15:0] ex_c    [8];
    logic        ex_co   [8];
    logic        ex_ov   [8];

    add_pipe #(
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Single transfer into an empty pipe with the consumer always ready.
    task automatic do_one(input string tag, input logic [1:0] m, input logic [15:0] va,
                          input logic [15:0] vb, input logic [15:0] ec,
                          input logic eco, input logic eov);
        out_ready = 1'b1;
        mode      = m;
        a         = va;
        b         = vb;
        in_valid  = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_not_early"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_c"},         32'(c),         32'(ec));
        chk({tag, "_cout"},      32'(cout),      32'(eco));
        chk({tag, "_ovf"},       32'(ovf),       32'(eov));
        step();
        chk({tag, "_no_dup"},    32'(out_valid), 32'd0);
    endtask

    // Streams tv_* entries; out_ready is low for cycles [stall_lo, stall_hi).
    task automatic run_stream(input string tag, input int n, input int stall_lo,
                              input int stall_hi);
        int  sent = 0;
        int  recv = 0;
        logic fire_in;
        logic fire_out;
        for (int cyc = 0; cyc < 60 && recv < n; cyc++) begin
            out_ready = !(cyc >= stall_lo && cyc < stall_hi);
            in_valid  = (sent < n);
            if (sent < n) begin
                mode = tv_mode[sent];
                a    = tv_a[sent];
                b    = tv_b[sent];
            end
            #1;
            if (!out_ready && out_valid) begin
                chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
                chk({tag, "_stall_c_hold"},   32'(c),        32'(ex_c[recv]));
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                chk($sformatf("%s_c%0d", tag, recv),    32'(c),    32'(ex_c[recv]));
                chk($sformatf("%s_cout%0d", tag, recv), 32'(cout), 32'(ex_co[recv]));
                chk($sformatf("%s_ovf%0d", tag, recv),  32'(ovf),  32'(ex_ov[recv]));
                recv++;
            end
            if (fire_in) sent++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 32'(recv), 32'(n));
        step();
        step();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        mode      = MODE_ADD;
        a         = 16'h0005;
        b         = 16'h0006;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c",         32'(c),         32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("rst_discard", 32'(out_valid), 32'd0);

        do_one("add_basic", MODE_ADD, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0);
        do_one("add_carry", MODE_ADD, 16'hFFFF, 16'h0002, E_FFFF_P2, 1'b1, 1'b0);
        do_one("add_ovf",   MODE_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        do_one("sub_borrow", MODE_SUB, 16'h0003, 16'h0005, E_3_M_5, 1'b0, 1'b0);
        do_one("sub_ovf",   MODE_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

        tv_mode[0] = MODE_ADD; tv_a[0] = 16'h0001; tv_b[0] = 16'h0002;
        ex_c[0] = 16'h0003; ex_co[0] = 1'b0; ex_ov[0] = 1'b0;
        tv_mode[1] = MODE_ADD; tv_a[1] = 16'h0010; tv_b[1] = 16'h0020;
        ex_c[1] = 16'h0030; ex_co[1] = 1'b0; ex_ov[1] = 1'b0;
        tv_mode[2] = MODE_SUB; tv_a[2] = 16'h0100; tv_b[2] = 16'h0001;
        ex_c[2] = 16'h00FF; ex_co[2] = 1'b1; ex_ov[2] = 1'b0;
        tv_mode[3] = MODE_ADD; tv_a[3] = 16'h8000; tv_b[3] = 16'h8000;
        ex_c[3] = E_8000_P2X; ex_co[3] = 1'b1; ex_ov[3] = 1'b1;
        run_stream("stall", 4, 2, 5);

        tv_mode[0] = MODE_CLR; tv_a[0] = 16'h1111; tv_b[0] = 16'h2222;
        ex_c[0] = 16'h0000; ex_co[0] = 1'b0; ex_ov[0] = 1'b0;
        tv_mode[1] = MODE_ACC; tv_a[1] = 16'h0005; tv_b[1] = 16'hFFFF;
        ex_c[1] = 16'h0005; ex_co[1] = 1'b0; ex_ov[1] = 1'b0;
        tv_mode[2] = MODE_ACC; tv_a[2] = 16'h0007; tv_b[2] = 16'hFFFF;
        ex_c[2] = 16'h000C; ex_co[2] = 1'b0; ex_ov[2] = 1'b0;
        tv_mode[3] = MODE_ACC; tv_a[3] = 16'h0010; tv_b[3] = 16'hFFFF;
        ex_c[3] = 16'h001C; ex_co[3] = 1'b0; ex_ov[3] = 1'b0;
        run_stream("acc", 4, 0, 0);

        do_one("add_keeps_acc", MODE_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
        do_one("acc_hold",      MODE_ACC, 16'h0000, 16'h1234, 16'h001C, 1'b0, 1'b0);

        out_ready = 1'b1;
        mode      = MODE_ADD;
        a         = 16'h0001;
        b         = 16'h0001;
        in_valid  = 1'b1;
        step();
        a = 16'h0002;
        step();
        in_valid = 1'b0;
        chk("midrst_inflight", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_c",         32'(c),         32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("midrst_stale%0d", i), 32'(out_valid), 32'd0);
        end
        do_one("acc_after_rst", MODE_ACC, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
